// File: rtl/trap_pipe_ctrl.sv
// Pipeline/trap controller: arbitrates branch/jump/fence redirects, WB-stage
// exceptions, mret and prioritised interrupts. Runs a multi-cycle flush window
// before the trap redirect and generates per-stage stall/bubble vectors.
module trap_pipe_ctrl #(
  parameter int XLEN         = 32,
  parameter int STAGES       = 5,
  parameter int NIRQ         = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic              jump_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   jump_target,
  input  logic              fence,
  input  logic [XLEN-1:0]   pc_if,
  input  logic [XLEN-1:0]   pc_wb,
  input  logic              exc_valid_wb,
  input  logic [4:0]        exc_code_wb,
  input  logic              mret_wb,
  input  logic [NIRQ-1:0]   irq_pending,
  input  logic [NIRQ*5-1:0] irq_cause,
  input  logic              irq_global_en,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic [STAGES-1:0] stall_req,
  output logic              set_pc_valid,
  output logic [XLEN-1:0]   set_pc,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] stall,
  output logic              mcause_update,
  output logic [XLEN-1:0]   mcause,
  output logic              mepc_update,
  output logic [XLEN-1:0]   mepc_wdata,
  output logic [NIRQ-1:0]   irq_ack,
  output logic              busy
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] target, target_nxt;

  logic [NIRQ-1:0]   irq_sel;
  logic [4:0]        irq_code;
  logic              irq_found;
  logic [STAGES-1:0] stall_vec;
  logic [STAGES-1:0] bubble_vec;
  logic              stall_hit;
  int unsigned       stall_k;
  logic [XLEN-1:0]   mtvec_base;

  // Interrupt priority encoder: the lowest pending index wins.
  always_comb begin
    irq_sel   = '0;
    irq_code  = '0;
    irq_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (!irq_found && irq_pending[i]) begin
        irq_found  = 1'b1;
        irq_sel[i] = 1'b1;
        irq_code   = irq_cause[5*i +: 5];
      end
    end
  end

  // Stall spread below the highest requesting stage plus a bubble just above it.
  always_comb begin
    stall_hit  = 1'b0;
    stall_k    = 0;
    stall_vec  = '0;
    bubble_vec = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stall_req[i]) begin
        stall_hit = 1'b1;
        stall_k   = i;
      end
    end
    for (int unsigned i = 0; i < STAGES; i++) begin
      stall_vec[i]  = stall_hit && (i <= stall_k);
      bubble_vec[i] = stall_hit && (i == stall_k + 1);
    end
  end

  assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};

  // Next-state and output decode; reset forces the documented idle values.
  always_comb begin
    logic              exc_ev, mret_ev, irq_ev, trap_ev;
    logic [STAGES-1:0] redir_flush;
    state_nxt     = state;
    cnt_nxt       = cnt;
    target_nxt    = target;
    set_pc_valid  = 1'b0;
    set_pc        = '0;
    flush         = '0;
    stall         = '0;
    mcause_update = 1'b0;
    mcause        = '0;
    mepc_update   = 1'b0;
    mepc_wdata    = '0;
    irq_ack       = '0;
    busy          = 1'b0;
    exc_ev        = 1'b0;
    mret_ev       = 1'b0;
    irq_ev        = 1'b0;
    trap_ev       = 1'b0;
    redir_flush   = '0;
    if (reset) begin
      flush = '1;
    end else if (state == FLUSH) begin
      flush = '1;
      busy  = 1'b1;
      if (cnt == CNT_LAST) begin
        set_pc_valid = 1'b1;
        set_pc       = target;
        state_nxt    = IDLE;
        cnt_nxt      = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else begin
      exc_ev  = exc_valid_wb;
      mret_ev = !exc_valid_wb && mret_wb;
      irq_ev  = !exc_valid_wb && !mret_wb && irq_global_en && irq_found;
      trap_ev = exc_ev || mret_ev || irq_ev;

      // Branch/jump flush of IF/ID stays even when a trap takes the redirect.
      if (branch_taken || jump_taken)
        redir_flush[1:0] = 2'b11;
      else if (fence && !trap_ev)
        redir_flush[0] = 1'b1;

      flush = redir_flush | bubble_vec;
      stall = stall_vec & ~redir_flush;

      if (trap_ev) begin
        state_nxt = FLUSH;
        cnt_nxt   = '0;
        if (exc_ev) begin
          mcause_update = 1'b1;
          mepc_update   = 1'b1;
          mepc_wdata    = pc_wb;
          mcause        = {{(XLEN-5){1'b0}}, exc_code_wb};
          target_nxt    = mtvec_base;
        end else if (mret_ev) begin
          target_nxt = mepc;
        end else begin
          mcause_update = 1'b1;
          mepc_update   = 1'b1;
          mepc_wdata    = pc_wb;
          mcause        = {1'b1, {(XLEN-6){1'b0}}, irq_code};
          irq_ack       = irq_sel;
          if (mtvec[1:0] == 2'b01)
            target_nxt = mtvec_base + {{(XLEN-7){1'b0}}, irq_code, 2'b00};
          else
            target_nxt = mtvec_base;
        end
      end else if (branch_taken) begin
        set_pc_valid = 1'b1;
        set_pc       = branch_target;
      end else if (jump_taken) begin
        set_pc_valid = 1'b1;
        set_pc       = jump_target;
      end else if (fence) begin
        set_pc_valid = 1'b1;
        set_pc       = pc_if;
      end
    end
  end

  // State, flush counter and latched trap target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
    end
  end

endmodule

// File: tb/tb_trap_pipe_ctrl.sv
// Self-checking bench for trap_pipe_ctrl: table of single-cycle IDLE vectors
// with follow-up redirect checks, plus hand sequences for long flush and reset.
module tb_trap_pipe_ctrl;

  localparam logic [14:0] IRQC = {5'd11, 5'd3, 5'd7};
  localparam logic [31:0] BT = 32'h200, JT = 32'h300, PCIF = 32'h40, PCWB = 32'h100, MEPC = 32'h240;

  logic        clk, reset;
  logic        branch_taken, jump_taken, fence, exc_valid_wb, mret_wb, irq_global_en;
  logic [31:0] branch_target, jump_target, pc_if, pc_wb, mtvec, mepc;
  logic [4:0]  exc_code_wb, stall_req;
  logic [2:0]  irq_pending;
  logic [14:0] irq_cause;

  logic        spv1, mcu1, meu1, busy1, spv3, mcu3, meu3, busy3;
  logic [31:0] spc1, mc1, mew1, spc3, mc3, mew3;
  logic [4:0]  fl1, st1, fl3, st3;
  logic [2:0]  ack1, ack3;

  int tests = 0;
  int errors = 0;

  trap_pipe_ctrl #(.XLEN(32), .STAGES(5), .NIRQ(3), .FLUSH_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .branch_target(branch_target), .jump_target(jump_target), .fence(fence),
    .pc_if(pc_if), .pc_wb(pc_wb), .exc_valid_wb(exc_valid_wb), .exc_code_wb(exc_code_wb),
    .mret_wb(mret_wb), .irq_pending(irq_pending), .irq_cause(irq_cause),
    .irq_global_en(irq_global_en), .mtvec(mtvec), .mepc(mepc), .stall_req(stall_req),
    .set_pc_valid(spv1), .set_pc(spc1), .flush(fl1), .stall(st1), .mcause_update(mcu1),
    .mcause(mc1), .mepc_update(meu1), .mepc_wdata(mew1), .irq_ack(ack1), .busy(busy1));

  trap_pipe_ctrl #(.XLEN(32), .STAGES(5), .NIRQ(3), .FLUSH_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .branch_target(branch_target), .jump_target(jump_target), .fence(fence),
    .pc_if(pc_if), .pc_wb(pc_wb), .exc_valid_wb(exc_valid_wb), .exc_code_wb(exc_code_wb),
    .mret_wb(mret_wb), .irq_pending(irq_pending), .irq_cause(irq_cause),
    .irq_global_en(irq_global_en), .mtvec(mtvec), .mepc(mepc), .stall_req(stall_req),
    .set_pc_valid(spv3), .set_pc(spc3), .flush(fl3), .stall(st3), .mcause_update(mcu3),
    .mcause(mc3), .mepc_update(meu3), .mepc_wdata(mew3), .irq_ack(ack3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br, jp, fn, exc;
    logic [4:0]  code;
    logic        mret;
    logic [2:0]  irqp;
    logic        gen;
    logic [31:0] mtvec;
    logic [4:0]  sreq;
    logic        spv;
    logic [31:0] spc;
    logic [4:0]  fl, st;
    logic        mcu;
    logic [31:0] mc;
    logic        meu;
    logic [31:0] mew;
    logic [2:0]  ack;
    logic        trap;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    branch_taken = 1'b0; jump_taken = 1'b0; fence = 1'b0; exc_valid_wb = 1'b0;
    exc_code_wb = 5'd0; mret_wb = 1'b0; irq_pending = 3'b000; irq_global_en = 1'b0;
    stall_req = 5'b00000; mtvec = 32'h0;
    branch_target = BT; jump_target = JT; pc_if = PCIF; pc_wb = PCWB; mepc = MEPC;
    irq_cause = IRQC;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    branch_taken = v.br; jump_taken = v.jp; fence = v.fn; exc_valid_wb = v.exc;
    exc_code_wb = v.code; mret_wb = v.mret; irq_pending = v.irqp; irq_global_en = v.gen;
    mtvec = v.mtvec; stall_req = v.sreq;
  endtask

  initial begin
    // br jp fn exc code mret irqp gen mtvec sreq | spv spc fl st mcu mc meu mew ack trap tgt
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b1,BT,5'b00011,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b1,JT,5'b00011,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b1,PCIF,5'b00001,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b1,BT,5'b00011,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00000, 1'b1,JT,5'b00011,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00100, 1'b0,32'h0,5'b01000,5'b00111,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00100, 1'b1,BT,5'b01011,5'b00100,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b10000, 1'b0,32'h0,5'b00000,5'b11111,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,5'd0,1'b0,3'b000,1'b0,32'h0,5'b00001, 1'b1,PCIF,5'b00011,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,5'd2,1'b0,3'b000,1'b0,32'h8000_0000,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b1,32'h2,1'b1,PCWB,3'b000,1'b1,32'h8000_0000};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b110,1'b1,32'h1001,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b1,32'h8000_0003,1'b1,PCWB,3'b010,1'b1,32'h100C};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b110,1'b0,32'h1001,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b0,32'h0};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,5'd5,1'b1,3'b000,1'b0,32'h8000_0000,5'b00000, 1'b0,32'h0,5'b00011,5'b00000,1'b1,32'h5,1'b1,PCWB,3'b000,1'b1,32'h8000_0000};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b1,3'b000,1'b0,32'h8000_0000,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,1'b0,32'h0,3'b000,1'b1,MEPC};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'b001,1'b1,32'h1000,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b1,32'h8000_0007,1'b1,PCWB,3'b001,1'b1,32'h1000};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,5'd1,1'b0,3'b001,1'b1,32'h2003,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b1,32'h1,1'b1,PCWB,3'b000,1'b1,32'h2000};
    vecs[17] = '{1'b0,1'b1,1'b0,1'b0,5'd0,1'b0,3'b100,1'b1,32'h1001,5'b00010, 1'b0,32'h0,5'b00111,5'b00000,1'b1,32'h8000_000B,1'b1,PCWB,3'b100,1'b1,32'h102C};
    vecs[18] = '{1'b0,1'b0,1'b1,1'b1,5'd3,1'b0,3'b000,1'b0,32'h4,5'b00000, 1'b0,32'h0,5'b00000,5'b00000,1'b1,32'h3,1'b1,PCWB,3'b000,1'b1,32'h4};

    // Reset values hold even with active inputs.
    idle_inputs();
    reset = 1'b1;
    branch_taken = 1'b1; exc_valid_wb = 1'b1; stall_req = 5'b11111;
    irq_pending = 3'b111; irq_global_en = 1'b1;
    step();
    #4;
    check("rst flush", 64'(fl1), 64'(5'b11111));
    check("rst spv", 64'(spv1), 64'd0);
    check("rst spc", 64'(spc1), 64'd0);
    check("rst stall", 64'(st1), 64'd0);
    check("rst mcu", 64'(mcu1), 64'd0);
    check("rst mcause", 64'(mc1), 64'd0);
    check("rst meu", 64'(meu1), 64'd0);
    check("rst mepc_wdata", 64'(mew1), 64'd0);
    check("rst ack", 64'(ack1), 64'd0);
    check("rst busy", 64'(busy1), 64'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #4;
      check($sformatf("v%0d spv", i), 64'(spv1), 64'(vecs[i].spv));
      check($sformatf("v%0d spc", i), 64'(spc1), 64'(vecs[i].spc));
      check($sformatf("v%0d flush", i), 64'(fl1), 64'(vecs[i].fl));
      check($sformatf("v%0d stall", i), 64'(st1), 64'(vecs[i].st));
      check($sformatf("v%0d mcu", i), 64'(mcu1), 64'(vecs[i].mcu));
      check($sformatf("v%0d mcause", i), 64'(mc1), 64'(vecs[i].mc));
      check($sformatf("v%0d meu", i), 64'(meu1), 64'(vecs[i].meu));
      check($sformatf("v%0d mepc_wdata", i), 64'(mew1), 64'(vecs[i].mew));
      check($sformatf("v%0d ack", i), 64'(ack1), 64'(vecs[i].ack));
      check($sformatf("v%0d busy", i), 64'(busy1), 64'd0);
      step();
      idle_inputs();
      #4;
      if (vecs[i].trap) begin
        check($sformatf("v%0d T1 spv", i), 64'(spv1), 64'd1);
        check($sformatf("v%0d T1 spc", i), 64'(spc1), 64'(vecs[i].tgt));
        check($sformatf("v%0d T1 flush", i), 64'(fl1), 64'(5'b11111));
        check($sformatf("v%0d T1 busy", i), 64'(busy1), 64'd1);
      end else begin
        check($sformatf("v%0d T1 busy", i), 64'(busy1), 64'd0);
        check($sformatf("v%0d T1 spv", i), 64'(spv1), 64'd0);
      end
      step();
      #4;
      check($sformatf("v%0d T2 busy", i), 64'(busy1), 64'd0);
      repeat (3) step();
    end

    // Long flush window: inputs ignored, redirect only in the last cycle.
    exc_valid_wb = 1'b1; exc_code_wb = 5'd4; mtvec = 32'h300;
    #4;
    check("lf T mcause", 64'(mc3), 64'h4);
    check("lf T mcu", 64'(mcu3), 64'd1);
    check("lf T busy", 64'(busy3), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      idle_inputs();
      if (c < 3) begin
        branch_taken = 1'b1; exc_valid_wb = 1'b1; stall_req = 5'b00100;
      end
      #4;
      check($sformatf("lf T%0d busy", c), 64'(busy3), 64'd1);
      check($sformatf("lf T%0d flush", c), 64'(fl3), 64'(5'b11111));
      check($sformatf("lf T%0d stall", c), 64'(st3), 64'd0);
      check($sformatf("lf T%0d mcu", c), 64'(mcu3), 64'd0);
      check($sformatf("lf T%0d spv", c), 64'(spv3), (c == 3) ? 64'd1 : 64'd0);
      check($sformatf("lf T%0d spc", c), 64'(spc3), (c == 3) ? 64'h300 : 64'd0);
    end
    step();
    #4;
    check("lf T4 busy", 64'(busy3), 64'd0);
    check("lf T4 spv", 64'(spv3), 64'd0);
    repeat (3) step();

    // Reset during the flush window aborts the redirect.
    mret_wb = 1'b1;
    step();
    idle_inputs();
    #4;
    check("ra T1 busy", 64'(busy3), 64'd1);
    step();
    reset = 1'b1;
    stall_req = 5'b00010;
    #4;
    check("ra rst flush", 64'(fl3), 64'(5'b11111));
    check("ra rst spv", 64'(spv3), 64'd0);
    check("ra rst spc", 64'(spc3), 64'd0);
    check("ra rst busy", 64'(busy3), 64'd0);
    check("ra rst stall", 64'(st3), 64'd0);
    step();
    reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #4;
      check($sformatf("ra post%0d spv", c), 64'(spv3), 64'd0);
      check($sformatf("ra post%0d busy", c), 64'(busy3), 64'd0);
      check($sformatf("ra post%0d flush", c), 64'(fl3), 64'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
